// File: rtl/fpdiv.sv
// Goldschmidt divider datapath: one 28x28 multiplier feeding registers RA, RB and RC, all steered by external selects and enables.
// Define FPDIV_IA_ROM_EN to take the initial approximation from a 64-entry reciprocal table instead of the constant 2/3.
module fpdiv (
   input  logic [27:0] d,
   input  logic [27:0] x,
   input  logic [1:0]  sel_muxa,
   input  logic [1:0]  sel_muxb,
   input  logic        enA,
   input  logic        enB,
   input  logic        enC,
   input  logic        clk,
   input  logic        reset,
   output logic [27:0] q,
   output logic [27:0] dk
);

   typedef enum logic [1:0] {
      A_RC = 2'b00,
      A_RA = 2'b01,
      A_IA = 2'b10,
      A_RB = 2'b11
   } sel_a_e;

   typedef enum logic [1:0] {
      B_D  = 2'b00,
      B_X  = 2'b01,
      B_RB = 2'b10,
      B_RA = 2'b11
   } sel_b_e;

   logic [27:0] ra_q, ra_d;
   logic [27:0] rb_q, rb_d;
   logic [27:0] rc_q, rc_d;
   logic [27:0] ia;
   logic [27:0] mux_a, mux_b;
   logic [55:0] prod;
   logic [27:0] p;
   logic        unused_prod_bits;

`ifdef FPDIV_IA_ROM_EN
   // round(16384 / (64 + i + 0.5)) rewritten in integers as floor((65536 + n) / 2n), n = 129 + 2i.
   function automatic logic [7:0] ia_entry(input int i);
      int n;
      n = 129 + 2 * i;
      return 8'((65536 + n) / (2 * n));
   endfunction

   logic [7:0] ia_rom [64];

   for (genvar g = 0; g < 64; g++) begin : g_ia_rom
      assign ia_rom[g] = ia_entry(g);
   end

   assign ia = {1'b0, ia_rom[d[26:21]], 19'b0};
`else
   assign ia = 28'h5555555;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      mux_a = rc_q;
      mux_b = d;
      unique case (sel_a_e'(sel_muxa))
         A_RC: mux_a = rc_q;
         A_RA: mux_a = ra_q;
         A_IA: mux_a = ia;
         A_RB: mux_a = rb_q;
         default: mux_a = rc_q;
      endcase
      unique case (sel_b_e'(sel_muxb))
         B_D:  mux_b = d;
         B_X:  mux_b = x;
         B_RB: mux_b = rb_q;
         B_RA: mux_b = ra_q;
         default: mux_b = d;
      endcase
   end

   // Q1.27 * Q1.27 = Q2.54; keep bits [54:27], truncating and dropping the top integer bit.
   assign prod             = 56'(mux_a) * 56'(mux_b);
   assign p                = prod[54:27];
   assign unused_prod_bits = ^{prod[55], prod[26:0]};

   always_comb begin
      ra_d = ra_q;
      rb_d = rb_q;
      rc_d = rc_q;
      if (enA) ra_d = p;
      if (enB) rb_d = p;
      if (enC) rc_d = (~p) + 28'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so all three registers see the same pre-edge product.
   always_ff @(posedge clk) begin
      if (reset) begin
         ra_q <= '0;
         rb_q <= '0;
         rc_q <= '0;
      end else begin
         ra_q <= ra_d;
         rb_q <= rb_d;
         rc_q <= rc_d;
      end
   end

   assign q  = rb_q;
   assign dk = ra_q;

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: a reference model pushes expected register contents to a queue, popped after each edge.
// Covers both builds; known Goldschmidt values are checked for whichever FPDIV_IA_ROM_EN setting is compiled.
module tb_fpdiv;

   logic [27:0] d, x;
   logic [1:0]  sel_muxa, sel_muxb;
   logic        enA, enB, enC;
   logic        clk, reset;
   logic [27:0] q, dk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [27:0] m_ra = '0, m_rb = '0, m_rc = '0;
   logic [83:0] exp_q [$];

   fpdiv dut (
      .d(d), .x(x), .sel_muxa(sel_muxa), .sel_muxb(sel_muxb),
      .enA(enA), .enB(enB), .enC(enC), .clk(clk), .reset(reset),
      .q(q), .dk(dk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [27:0] model_ia(input logic [27:0] dd);
`ifdef FPDIV_IA_ROM_EN
      int  idx;
      real r;
      idx = int'(dd[26:21]);
      r   = 16384.0 / (64.0 + idx + 0.5);
      return {1'b0, 8'($rtoi(r + 0.5)), 19'b0};
`else
      return 28'h5555555 + 28'(dd & 28'h0);
`endif
   endfunction

   // Drive one cycle on the falling edge, predict, then compare just after the rising edge.
   task automatic step(input logic [1:0] a, input logic [1:0] b,
                       input logic ea, input logic eb, input logic ec, input logic rs);
      logic [27:0] ma, mb, p;
      logic [55:0] full;
      logic [83:0] e;
      @(negedge clk);
      sel_muxa = a; sel_muxb = b;
      enA = ea; enB = eb; enC = ec; reset = rs;
      case (a)
         2'b00:   ma = m_rc;
         2'b01:   ma = m_ra;
         2'b10:   ma = model_ia(d);
         default: ma = m_rb;
      endcase
      case (b)
         2'b00:   mb = d;
         2'b01:   mb = x;
         2'b10:   mb = m_rb;
         default: mb = m_ra;
      endcase
      full = {28'b0, ma} * {28'b0, mb};
      p    = full[54:27];
      if (rs) begin
         m_ra = '0; m_rb = '0; m_rc = '0;
      end else begin
         if (ea) m_ra = p;
         if (eb) m_rb = p;
         if (ec) m_rc = 28'(29'h10000000 - {1'b0, p});
      end
      exp_q.push_back({m_rb, m_ra, m_rc});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("q", q, e[83:56]);
      check("dk", dk, e[55:28]);
      check("rc", dut.rc_q, e[27:0]);
   endtask

   task automatic goldschmidt_1to4();
      step(2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef FPDIV_IA_ROM_EN
      check("s1_q", q, 28'h94C0000);
`endif
      step(2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FPDIV_IA_ROM_EN
      check("s2_dk", dk, 28'h7F80000);
      check("s2_rc", dut.rc_q, 28'h8080000);
`endif
      step(2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      step(2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FPDIV_IA_ROM_EN
      check("s4_q", q, 28'h9554C00);
      check("s4_dk", dk, 28'h7FFF800);
      check("s4_rc", dut.rc_q, 28'h8000800);
`endif
   endtask

   initial begin
      d = 28'hC000000; x = 28'hE000000;
      sel_muxa = '0; sel_muxb = '0;
      enA = 1'b0; enB = 1'b0; enC = 1'b0; reset = 1'b0;

      // Reset with every enable high still clears everything.
      step(2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_q", q, 28'h0);
      check("rst_dk", dk, 28'h0);
      check("rst_rc", dut.rc_q, 28'h0);

      goldschmidt_1to4();

      // Enables low with wandering selects: nothing may move.
      for (int i = 0; i < 5; i++)
         step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FPDIV_IA_ROM_EN
      check("hold_q", q, 28'h9554C00);
      check("hold_dk", dk, 28'h7FFF800);
      check("hold_rc", dut.rc_q, 28'h8000800);
`endif

      // Reset between steps 2 and 3, then a clean rerun.
      step(2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      step(2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      step(2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
      check("mid_rst_q", q, 28'h0);
      check("mid_rst_dk", dk, 28'h0);
      goldschmidt_1to4();

`ifndef FPDIV_IA_ROM_EN
      x = 28'h8000000;
      step(2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      check("const_ia_q", q, 28'h5555555);
`endif

      // Random operands, selects and enable mixes, with occasional reset.
      for (int n = 0; n < 40; n++) begin
         d = {1'b1, 27'($urandom)};
         x = {1'b1, 27'($urandom)};
         step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpdiv.md
FPDIV -- requirements
Module: fpdiv

Interface
Parameters: none.
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 d  input  28  divisor, unsigned Q1.27 (bit 27 integer, bits 26:0 fraction), normalized to [1,2).
REQ-004 x  input  28  dividend, unsigned Q1.27, normalized to [1,2).
REQ-005 sel_muxa  input  2  multiplicand select.
REQ-006 sel_muxb  input  2  multiplier select.
REQ-007 enA  input  1  load enable, register RA (divisor-path product).
REQ-008 enB  input  1  load enable, register RB (quotient approximation).
REQ-009 enC  input  1  load enable, register RC (correction factor 2 - product).
REQ-010 q  output  28  RB contents, quotient approximation, Q1.27.
REQ-011 dk  output  28  RA contents, divisor-path product, Q1.27.
REQ-012 Positional port order SHALL be d, x, sel_muxa, sel_muxb, enA, enB, enC, clk, reset, q, dk.

Function
REQ-013 Datapath SHALL be one 28x28 unsigned combinational multiplier, p = muxA * muxB, with three 28-bit registers RA, RB, RC.
REQ-014 muxA SHALL select: 00 RC, 01 RA, 10 IA (initial approximation), 11 RB.
REQ-015 muxB SHALL select: 00 d, 01 x, 10 RB, 11 RA.
REQ-016 Multiplier output SHALL be the 56-bit Q2.54 product truncated to Q1.27 as product bits [54:27]; no rounding; bit 55 discarded.
REQ-017 Each register SHALL load on the rising edge when its enable is high, else hold; RA and RB load the truncated product.
REQ-018 RC SHALL load the two's complement of the truncated product modulo 2^28 (i.e. 2 - p in Q1.27).
REQ-019 Any combination of enables SHALL be legal in one cycle; all enabled registers capture the same product.
REQ-020 Outputs SHALL be registered: q and dk change only on the clock edge after a load.
REQ-021 Standard Goldschmidt sequence (one cycle per step): (1) a=10, b=01, enB -> RB=x*IA; (2) a=10, b=00, enA+enC -> RA=d*IA, RC=2-RA; (3) a=00, b=10, enB -> RB=RB*RC; (4) a=00, b=11, enA+enC -> RA=RA*RC, RC=2-RA; steps 3-4 repeat per further iteration.
REQ-022 Block SHALL contain no sequencer; control comes entirely from select/enable inputs.

Reset
REQ-023 reset high at a rising edge SHALL clear RA, RB, RC (so q, dk) to 0 regardless of enables.
REQ-024 reset SHALL take priority over enables, including mid-sequence; no other state exists.

Configuration
REQ-025 With FPDIV_IA_ROM_EN defined, IA SHALL be {1'b0, T[i], 19'b0}, i = d[26:21], T[i] = round(16384/(64+i+0.5)) (8-bit, purely combinational 64-entry table).
REQ-026 Without FPDIV_IA_ROM_EN, IA SHALL be constant 28'h5555555 (about 2/3).

Verification (FPDIV_IA_ROM_EN defined unless noted; d=28'hC000000 (1.5), x=28'hE000000 (1.75); IA=170/256)
REQ-027 Reset held one cycle with all enables high -> q=0, dk=0, RC=0.
REQ-028 Step 1 -> q=28'h94C0000; step 2 -> dk=28'h7F80000, RC=28'h8080000.
REQ-029 Steps 3 and 4 -> q=28'h9554C00, dk=28'h7FFF800, RC=28'h8000800.
REQ-030 All enables low for several cycles with toggling selects -> q, dk, RC unchanged.
REQ-031 Reset asserted between steps 2 and 3 -> all registers 0 next edge; rerunning steps 1-4 reproduces REQ-028/029 values.
REQ-032 Without FPDIV_IA_ROM_EN, step 1 with x=28'h8000000 (1.0) -> q=28'h5555555.
